// File: rtl/dec_stage_if.sv
// Fetch/execute handshake bundle for the registered decode stage.
interface dec_stage_if #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5,
  parameter int PC_W     = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_inst;
  logic [PC_W-1:0]     in_pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [PC_W-1:0]     out_pc;
  logic [REG_ID_W-1:0] out_rd;
  logic [REG_ID_W-1:0] out_rs1;
  logic [REG_ID_W-1:0] out_rs2;
  logic [XLEN-1:0]     out_imm;
  logic [3:0]          out_alu_op;
  logic [2:0]          out_funct3;
  logic [3:0]          out_type;
  logic                out_illegal;
  logic                halted;

  // Fetch/execute side: drives instructions and the accept strobe.
  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_imm, out_alu_op, out_funct3, out_type, out_illegal, halted
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_imm, out_alu_op, out_funct3, out_type, out_illegal, halted
  );
endinterface

// File: rtl/dec_stage.sv
// Registered RV32I/RV32E decode stage with a 2-entry skid buffer and a
// halt state that freezes the stage after EBREAK or an illegal instruction.
module dec_stage #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5,
  parameter int RV32E    = 0,
  parameter int PC_W     = 32
) (
  input logic       clock,
  input logic       reset,
  dec_stage_if.slave bus
);

  generate
    if (XLEN != 32) begin : g_xlen_check
      $error("dec_stage supports only XLEN=32");
    end
  endgenerate

  localparam logic [3:0] T_NONE   = 4'd0;
  localparam logic [3:0] T_REG    = 4'd1;
  localparam logic [3:0] T_IMM    = 4'd2;
  localparam logic [3:0] T_LUI    = 4'd3;
  localparam logic [3:0] T_AUIPC  = 4'd4;
  localparam logic [3:0] T_JAL    = 4'd5;
  localparam logic [3:0] T_JALR   = 4'd6;
  localparam logic [3:0] T_BRANCH = 4'd7;
  localparam logic [3:0] T_LOAD   = 4'd8;
  localparam logic [3:0] T_STORE  = 4'd9;
  localparam logic [3:0] T_ECALL  = 4'd10;
  localparam logic [3:0] T_EBREAK = 4'd11;

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [REG_ID_W-1:0] rd;
    logic [REG_ID_W-1:0] rs1;
    logic [REG_ID_W-1:0] rs2;
    logic [XLEN-1:0]     imm;
    logic [3:0]          alu_op;
    logic [2:0]          funct3;
    logic [3:0]          itype;
    logic                illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO, HALTED} state_t;

  state_t state_q;
  entry_t main_q, skid_q, dec_d;
  logic   in_ready_q, out_valid_q, halted_q;
  logic   use_rd, use_rs1, use_rs2, ill;

  logic [31:0] inst;
  logic [6:0]  opcode, f7;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [2:0]  f3;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign f_rd   = inst[11:7];
  assign f3     = inst[14:12];
  assign f_rs1  = inst[19:15];
  assign f_rs2  = inst[24:20];
  assign f7     = inst[31:25];

  // Decode the incoming word into a buffer entry; illegal words collapse to a bare marker.
  always_comb begin
    dec_d        = '0;
    dec_d.pc     = bus.in_pc;
    dec_d.funct3 = f3;
    ill          = (inst[1:0] != 2'b11);
    use_rd       = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_d.itype  = T_REG;
        dec_d.alu_op = {inst[30], f3};
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
        if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
      end
      7'b0010011: begin
        dec_d.itype  = T_IMM;
        dec_d.imm    = {{20{inst[31]}}, inst[31:20]};
        dec_d.alu_op = {inst[30] & (f3 == 3'b101), f3};
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
      end
      7'b0110111: begin
        dec_d.itype = T_LUI;
        dec_d.imm   = {inst[31:12], 12'b0};
        use_rd = 1'b1;
      end
      7'b0010111: begin
        dec_d.itype = T_AUIPC;
        dec_d.imm   = {inst[31:12], 12'b0};
        use_rd = 1'b1;
      end
      7'b1101111: begin
        dec_d.itype = T_JAL;
        dec_d.imm   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        use_rd = 1'b1;
      end
      7'b1100111: begin
        dec_d.itype = T_JALR;
        dec_d.imm   = {{20{inst[31]}}, inst[31:20]};
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 != 3'b000) ill = 1'b1;
      end
      7'b1100011: begin
        dec_d.itype = T_BRANCH;
        dec_d.imm   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      7'b0000011: begin
        dec_d.itype = T_LOAD;
        dec_d.imm   = {{20{inst[31]}}, inst[31:20]};
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      end
      7'b0100011: begin
        dec_d.itype = T_STORE;
        dec_d.imm   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f3 >= 3'b011) ill = 1'b1;
      end
      7'b0001111: dec_d.itype = T_NONE;
      7'b1110011: begin
        if (inst == 32'h0000_0073)      dec_d.itype = T_ECALL;
        else if (inst == 32'h0010_0073) dec_d.itype = T_EBREAK;
        else                            ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    dec_d.rd  = use_rd  ? REG_ID_W'(f_rd)  : '0;
    dec_d.rs1 = use_rs1 ? REG_ID_W'(f_rs1) : '0;
    dec_d.rs2 = use_rs2 ? REG_ID_W'(f_rs2) : '0;
    if (RV32E != 0 && ((use_rd && f_rd[4]) || (use_rs1 && f_rs1[4]) || (use_rs2 && f_rs2[4])))
      ill = 1'b1;
    if (ill) begin
      dec_d         = '0;
      dec_d.pc      = bus.in_pc;
      dec_d.illegal = 1'b1;
    end
  end

  logic accept, drain, halt_main;
  assign accept    = bus.in_valid & in_ready_q;
  assign drain     = out_valid_q & bus.out_ready;
  assign halt_main = (main_q.itype == T_EBREAK) | main_q.illegal;

  // Buffer/halt FSM: halting drains win over flush, flush wins over accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept && !bus.flush) begin
            main_q      <= dec_d;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (drain && halt_main) begin
            state_q     <= HALTED;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b1;
          end else if (bus.flush) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (accept && drain) begin
            main_q <= dec_d;
          end else if (accept) begin
            skid_q     <= dec_d;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (drain && halt_main) begin
            state_q     <= HALTED;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b1;
          end else if (bus.flush) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end else if (drain) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.halted      = halted_q;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_alu_op  = main_q.alu_op;
  assign bus.out_funct3  = main_q.funct3;
  assign bus.out_type    = main_q.itype;
  assign bus.out_illegal = main_q.illegal;

endmodule
